// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan motor drive: state encoding, widths
// and the saturating duty-ramp step.
package fan_pkg;

    localparam int SPEED_MAX = 3;
    localparam int SPEED_W   = 3;
    localparam int DUTY_W    = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_RUN  = 2'd3
    } fan_drv_state_t;

    // One ramp step of at most inc toward tgt; lands exactly on tgt, never past it.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] tgt,
                                                   input logic [DUTY_W-1:0] inc);
        logic [DUTY_W:0] up;
        up = {1'b0, duty} + {1'b0, inc};
        if (duty < tgt)
            return (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        else
            return ((duty - tgt) > inc) ? (duty - inc) : tgt;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM frame counter and registered comparator. The duty input is the value
// that will be in force next cycle, so pwm_out stays aligned with cnt.
module fan_pwm_gen
    import fan_pkg::*;
#(
    parameter int PWM_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DUTY_W-1:0] duty,
    output logic              fb,
    output logic              pwm_out
);

    localparam logic [7:0] LAST = 8'(PWM_PERIOD - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       pwm_q, pwm_d;

    assign fb      = (cnt_q == LAST);
    assign pwm_out = pwm_q;

    always_comb begin
        cnt_d = 8'd0;
        pwm_d = 1'b0;
        if (!clear) begin
            cnt_d = fb ? 8'd0 : cnt_q + 8'd1;
            pwm_d = (cnt_d < duty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

endmodule

// File: rtl/fan_motor_drive.sv
// Motor drive: start-up kick, frame-rate soft ramp toward the speed target,
// and immediate shutdown on supply loss. PWM timing lives in fan_pwm_gen.
module fan_motor_drive
    import fan_pkg::*;
#(
    parameter int PWM_PERIOD  = 100,
    parameter int DUTY1       = 40,
    parameter int DUTY2       = 70,
    parameter int DUTY3       = 100,
    parameter int RAMP_INC    = 5,
    parameter int KICK_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               elec,
    input  logic [SPEED_W-1:0] speed,
    output logic               pwm_out,
    output logic [DUTY_W-1:0]  duty_now,
    output logic               at_speed,
    output logic [1:0]         state
);

    localparam logic [DUTY_W-1:0] FULL = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] INC  = DUTY_W'(RAMP_INC);
    localparam logic [7:0]        KICK = 8'(KICK_FRAMES);

    fan_drv_state_t    state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [7:0]        kick_q, kick_d;
    logic [DUTY_W-1:0] tgt, step;
    logic              fb;

    always_comb begin
        case (speed)
            3'd0:    tgt = '0;
            3'd1:    tgt = DUTY_W'(DUTY1);
            3'd2:    tgt = DUTY_W'(DUTY2);
            default: tgt = DUTY_W'(DUTY3);
        endcase
    end

    assign step = ramp_step(duty_q, tgt, INC);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        kick_d  = kick_q;
        if (!elec) begin
            state_d = ST_OFF;
            duty_d  = '0;
            kick_d  = 8'd0;
        end else if (fb) begin
            case (state_q)
                ST_OFF: begin
                    if (tgt != '0) begin
                        state_d = ST_KICK;
                        kick_d  = KICK;
                        duty_d  = FULL;
                    end
                end
                ST_KICK: begin
                    // Leaving the kick applies the first ramp step in the same boundary.
                    kick_d = kick_q - 8'd1;
                    if (kick_d == 8'd0 || tgt == '0) begin
                        kick_d  = 8'd0;
                        state_d = ST_RAMP;
                        duty_d  = step;
                    end
                end
                ST_RAMP: begin
                    duty_d = step;
                    if (step == tgt)
                        state_d = (tgt != '0) ? ST_RUN : ST_OFF;
                end
                ST_RUN: begin
                    if (tgt != duty_q) begin
                        state_d = ST_RAMP;
                        duty_d  = step;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            duty_q  <= '0;
            kick_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            kick_q  <= kick_d;
        end
    end

    fan_pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!elec),
        .duty    (duty_d),
        .fb      (fb),
        .pwm_out (pwm_out)
    );

    assign duty_now = duty_q;
    assign state    = state_q;
    assign at_speed = (state_q == ST_RUN) || (state_q == ST_OFF && tgt == '0);

endmodule

// File: tb/tb_fan_motor_drive.sv
// Scoreboard bench: stimulus advances a frame-level reference model and queues
// the expected outputs; a monitor compares each clock's DUT outputs.
module tb_fan_motor_drive;

    localparam int P  = 10;
    localparam int D1 = 4;
    localparam int D2 = 7;
    localparam int D3 = 10;
    localparam int I  = 2;
    localparam int K  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       elec = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       pwm_out;
    logic [7:0] duty_now;
    logic       at_speed;
    logic [1:0] state;

    fan_motor_drive #(
        .PWM_PERIOD(P), .DUTY1(D1), .DUTY2(D2), .DUTY3(D3),
        .RAMP_INC(I), .KICK_FRAMES(K)
    ) dut (
        .clk(clk), .rst_n(rst_n), .elec(elec), .speed(speed),
        .pwm_out(pwm_out), .duty_now(duty_now), .at_speed(at_speed), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pwm;
        int duty;
        int st;
        bit as;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    // Reference model state: position in frame, duty, mode (0..3), kick frames left.
    int m_cnt = 0, m_duty = 0, m_state = 0, m_kick = 0;
    bit m_pwm = 0;

    function automatic int tgt_of(input int sp);
        if (sp == 0) return 0;
        if (sp == 1) return D1;
        if (sp == 2) return D2;
        return D3;
    endfunction

    function automatic int approach(input int d, input int t);
        if (d < t) return (d + I < t) ? d + I : t;
        return (d - I > t) ? d - I : t;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_state = 0; m_kick = 0; m_pwm = 0;
    endtask

    task automatic model_step(input bit e, input int sp);
        int t;
        bit frame_end;
        t = tgt_of(sp);
        frame_end = (m_cnt == P - 1);
        if (!e) begin
            model_reset();
            return;
        end
        if (frame_end) begin
            case (m_state)
                0: if (t > 0) begin m_state = 1; m_kick = K; m_duty = P; end
                1: begin
                    m_kick = m_kick - 1;
                    if (m_kick == 0 || t == 0) begin
                        m_kick = 0; m_state = 2; m_duty = approach(m_duty, t);
                    end
                end
                2: begin
                    m_duty = approach(m_duty, t);
                    if (m_duty == t) m_state = (t > 0) ? 3 : 0;
                end
                default: if (t != m_duty) begin m_state = 2; m_duty = approach(m_duty, t); end
            endcase
        end
        m_cnt = frame_end ? 0 : m_cnt + 1;
        m_pwm = (m_cnt < m_duty);
    endtask

    task automatic push_exp(input int sp);
        exp_t x;
        x.pwm  = m_pwm;
        x.duty = m_duty;
        x.st   = m_state;
        x.as   = (m_state == 3) || (m_state == 0 && tgt_of(sp) == 0);
        q.push_back(x);
    endtask

    task automatic cyc(input bit e, input int sp);
        @(negedge clk);
        rst_n = 1'b1;
        elec  = e;
        speed = sp[2:0];
        model_step(e, sp);
        push_exp(sp);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic reset_cyc(input int sp);
        @(negedge clk);
        speed = sp[2:0];
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 1'b0 || duty_now !== 8'd0 || state !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: got pwm=%0b duty=%0d state=%0d, want 0/0/0",
                     pwm_out, duty_now, state);
        end
        model_reset();
        push_exp(sp);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() == 0) continue;
            x = q.pop_front();
            tests++;
            if (pwm_out !== x.pwm || duty_now !== 8'(x.duty) || state !== 2'(x.st) ||
                at_speed !== x.as) begin
                fails++;
                $display("FAIL scoreboard cyc=%0d: got pwm=%0b duty=%0d st=%0d at=%0b, want pwm=%0b duty=%0d st=%0d at=%0b",
                         cycle, pwm_out, duty_now, state, at_speed, x.pwm, x.duty, x.st, x.as);
            end
        end
    end

    initial begin
        int sp;
        bit e;
        repeat (3) reset_cyc(0);
        repeat (4) cyc(0, 0);
        repeat (90) cyc(1, 1);   // kick, ramp 8/6/4, run
        repeat (60) cyc(1, 3);   // 6, 8, 10, run
        repeat (60) cyc(1, 2);
        repeat (70) cyc(1, 0);   // 5, 3, 1, 0, off
        repeat (80) cyc(1, 5);   // same as speed 3
        repeat (25) cyc(1, 0);
        repeat (35) cyc(1, 1);   // into the kick/ramp
        repeat (5)  cyc(0, 1);   // supply loss
        repeat (90) cyc(1, 2);   // restart
        repeat (23) cyc(1, 3);
        repeat (3)  reset_cyc(3);
        repeat (60) cyc(1, 3);
        sp = 1; e = 1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) sp = int'($urandom_range(0, 7));
            if (e ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 5) == 0)) e = !e;
            if ($urandom_range(0, 999) == 0) reset_cyc(sp);
            else cyc(e, sp);
        end
        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fan_motor_drive.md
# fan_motor_drive

Downstream stage of the fan speed FSM: consumes its 3-bit `speed` code and the `elec` supply flag and drives the motor switch with a glitch-free PWM waveform. A start-up kick and a frame-rate soft ramp keep the motor from stalling or taking current steps when the speed code changes. All duty updates are applied only at PWM frame boundaries.

## Interface
- `PWM_PERIOD`, default 100: clocks per PWM frame; range 2..255.
- `DUTY1`, default 40: on-clocks per frame at speed 1; must be ≤ `PWM_PERIOD`.
- `DUTY2`, default 70: on-clocks per frame at speed 2; must be ≤ `PWM_PERIOD`.
- `DUTY3`, default 100: on-clocks per frame at speed 3; must be ≤ `PWM_PERIOD`.
- `RAMP_INC`, default 5: maximum duty change per frame; must be ≥ 1.
- `KICK_FRAMES`, default 4: number of full-on frames applied on start from standstill; must be ≥ 1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `elec` in 1: supply present.
- `speed` in 3: speed code from the fan FSM. 0 = off; 1..3 = speed level; codes >3 are treated as 3.
- `pwm_out` in→out 1, registered: motor switch drive.
- `duty_now` out 8: duty currently applied, in on-clocks per frame.
- `at_speed` out 1: high when state is RUN, or when state is OFF with target 0.
- `state` out 2: 0 = OFF, 1 = KICK, 2 = RAMP, 3 = RUN.

## Operation
- **Target duty** `tgt` (combinational from `speed`): 0 → 0, 1 → `DUTY1`, 2 → `DUTY2`, ≥3 → `DUTY3`.
- **Frame counter** `cnt`: counts 0..`PWM_PERIOD`-1 and wraps. The frame boundary `fb` is the cycle with `cnt == PWM_PERIOD-1`.
- **PWM output:** `pwm_out <= elec && (cnt_next < duty_next)`. Duty and state change only at `fb` (except on supply loss), so each frame's waveform comes from a single duty value.
- **Transitions at `fb`:**
  - **OFF:** if `elec` and `tgt > 0`, go to KICK, load the kick counter with `KICK_FRAMES`, and set duty to `PWM_PERIOD`.
  - **KICK:**
    - Decrement the kick counter.
    - When it reaches 0, go to RAMP.
    - If `tgt` becomes 0 during KICK, go to RAMP immediately.
  - **RAMP:**
    - Move duty toward `tgt` by `RAMP_INC`, saturating at `tgt` with no overshoot.
    - If the new duty equals `tgt > 0`, go to RUN.
    - If the new duty equals `tgt == 0`, go to OFF.
  - **RUN:** if `tgt != duty_now`, go to RAMP and apply the first step in the same boundary cycle.
- **Supply loss:** `elec == 0` in any state, in any cycle, forces the following on the next edge: state OFF, `duty_now = 0`, `cnt = 0`, kick counter 0, `pwm_out = 0`.
  - While `elec` stays 0, everything holds at these values.
  - When `elec` returns, restart follows the normal OFF→KICK path at the next `fb`.
- **Arithmetic:** 8-bit unsigned.
  - Ramp up: `min(duty + RAMP_INC, tgt)`.
  - Ramp down: `(duty - tgt > RAMP_INC) ? duty - RAMP_INC : tgt`. This is computed so no underflow is possible.
- **Reset values:** `state` OFF, `duty_now` 0, `cnt` 0, `pwm_out` 0, `at_speed` 1 (OFF with `tgt` 0 as reset default; combinational from `speed`), kick counter 0.

## Timing
- **`speed` change → duty change:** the first duty change appears at the next `fb`. The new waveform starts on the following clock (`cnt == 0`), so latency is ≤ `PWM_PERIOD` clocks.
- **`pwm_out`:** registered, aligned to `cnt`. It is high for exactly `duty_now` clocks at the start of each frame.
  - duty 0: output is constant low.
  - duty `PWM_PERIOD`: output is constant high.
- **Supply loss:** `pwm_out` goes low 1 clock after `elec` falls.
- **Simultaneous supply loss and `fb`:** supply loss wins.
- **Asynchronous reset:** mid-frame assertion clears all outputs immediately. Release is synchronous to `clk`; the first frame starts with `cnt = 0`.

## Structure
- **Shared package `fan_pkg`:**
  - state enum `fan_drv_state_t` (OFF/KICK/RAMP/RUN)
  - `SPEED_MAX = 3`
  - `SPEED_W = 3`
  - `DUTY_W = 8`
- **Sub-module `fan_pwm_gen`:** frame counter, comparator and registered output. It takes `duty` and a `clear` input and returns `fb`. The FSM, ramp arithmetic and kick counter stay in `fan_motor_drive`.

## Test plan
All scenarios use `PWM_PERIOD`=10, `DUTY1`=4, `DUTY2`=7, `DUTY3`=10, `RAMP_INC`=2, `KICK_FRAMES`=2.
- **Reset:** assert `rst_n`=0 mid-frame → `pwm_out`=0, `duty_now`=0, `state`=0 immediately; after release, `cnt` starts from 0.
- **Start from standstill:** `elec`=1, `speed`=1 → 2 frames at duty 10, then duty 8, 6, 4 on successive frames. State goes to RUN and `at_speed`=1, and `pwm_out` is then high 4 of every 10 clocks.
- **Speed up in RUN:** `speed` 1→3 in RUN at duty 4 → duty 6, 8, 10, then RUN.
- **Speed down to off:** `speed` 2→0 in RUN at duty 7 → duty 5, 3, 1, 0 (saturates, no underflow), then OFF.
- **Supply loss mid-ramp:** drop `elec` → next clock `pwm_out`=0, `duty_now`=0, OFF. Restore `elec` with `speed`=2 → KICK at the next `fb`, then ramp 8→7.
- **Out-of-range code:** `speed`=5 → behaves exactly as `speed`=3 (target 10).
